// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants, read-state type and bin reordering helper
package fft_pkg;

  localparam int DATA_W = 8;
  localparam int N      = 8;
  localparam int LOG2N  = 3;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  // The datapath leaves results in bit-reversed lane order.
  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// rtl/fft_frame_buf.sv - ping-pong pair of 8-lane frame banks with write/read pointers
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int DATA_W = fft_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [N-1:0][DATA_W-1:0]   wr_lanes_i,
  input  logic                       rd_release_i,
  input  logic [LOG2N-1:0]           rd_lane_i,
  output logic [DATA_W-1:0]          rd_data_o
);

  logic [DATA_W-1:0] bank_q [2][N];
  logic              wr_ptr_q;
  logic              wr_ptr_d;
  logic              rd_ptr_q;
  logic              rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_i) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (rd_release_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Bank storage carries no reset; the top never exposes it before a write.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < N; i++) begin
        bank_q[wr_ptr_q][i] <= wr_lanes_i[i];
      end
    end
  end

  assign rd_data_o = bank_q[rd_ptr_q][rd_lane_i];

endmodule

// File: rtl/fft_out_serializer.sv
// rtl/fft_out_serializer.sv - serialises 8-lane FFT frames into a natural-order sample stream
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int BITREV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  input  logic [DATA_W-1:0] in8,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  rd_state_e              state_q;
  rd_state_e              state_d;
  logic [LOG2N-1:0]       bin_q;
  logic [LOG2N-1:0]       bin_d;
  logic [1:0]             fill_q;
  logic [1:0]             fill_d;

  logic                   accept;
  logic                   handshake;
  logic                   release_bank;
  logic [LOG2N-1:0]       rd_lane;
  logic [DATA_W-1:0]      rd_data;
  logic [N-1:0][DATA_W-1:0] lanes;

  assign lanes = {in8, in7, in6, in5, in4, in3, in2, in1};

  assign in_ready     = (fill_q < 2'd2);
  assign out_valid    = (state_q == RD_STREAM);
  assign handshake    = out_valid && out_ready && !rst;
  assign accept       = in_valid && in_ready && !rst;
  assign release_bank = handshake && (bin_q == 3'd7);
  assign busy         = (fill_q != 2'd0);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    fill_d  = fill_q + {1'b0, accept} - {1'b0, release_bank};
    case (state_q)
      RD_IDLE: begin
        bin_d = '0;
        // Going straight to STREAM on the accept edge gives one-cycle latency.
        if ((fill_q != 2'd0) || accept) begin
          state_d = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (handshake) begin
          bin_d = bin_q + 3'd1;
          if (release_bank && (fill_d == 2'd0)) begin
            state_d = RD_IDLE;
          end
        end
      end
      default: begin
        state_d = RD_IDLE;
        bin_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RD_IDLE;
      bin_q   <= '0;
      fill_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      fill_q  <= fill_d;
    end
  end

  assign rd_lane = (BITREV != 0) ? bitrev3(bin_q) : bin_q;

  fft_frame_buf #(
    .DATA_W (DATA_W)
  ) u_frame_buf (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (accept),
    .wr_lanes_i   (lanes),
    .rd_release_i (release_bank),
    .rd_lane_i    (rd_lane),
    .rd_data_o    (rd_data)
  );

  // Gate with out_valid so undefined bank contents never reach the port.
  assign out_data  = out_valid ? rd_data : '0;
  assign out_index = out_valid ? bin_q : 3'd0;
  assign out_last  = out_valid && (bin_q == 3'd7);

endmodule
